// File: rtl/vpu_alu_wb_packer.sv
// ----------------------------------------------------------------------------
// vpu_alu_wb_packer
//   Consumer end of the VPU ALU result interface. Packs the per-element
//   result stream (right-justified in a 64-bit lane) into 64-bit VRF words,
//   either as SEW-sized elements or as one mask bit per element. A one-word
//   output buffer absorbs VRF backpressure and allows drain and refill in the
//   same cycle, giving one element per cycle.
//
// Optional feature (compile-time macro VPU_WB_TAIL_FILL_EN):
//   defined   - the final word gets all-ones data and write enable on every
//               bit beyond the last element (tail-agnostic fill).
//   undefined - tail bits are written with wmask = 0 and wdata = 0.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start_i        begin an instruction (sampled only in IDLE)
//   vl_i           element count 0..VLEN
//   vsew_i         element width (8/16/32/64)
//   vd_i           destination base register
//   mask_dest_i    1 = pack bit 0 of each result as one mask bit
//   elem_valid_i   ALU result valid
//   elem_en_i      ALU result enable (0 = element not written)
//   elem_data_i    ALU result, right-justified
//   elem_ready_o   element accepted when elem_valid_i && elem_ready_o
//   vrf_we_o       write request (output buffer valid)
//   vrf_ready_i    VRF accepts when vrf_we_o && vrf_ready_i
//   vrf_waddr_o    flat word address (vd*WPR + word) mod 32*WPR
//   vrf_wdata_o    packed word
//   vrf_wmask_o    bit-level write enable
//   busy_o         instruction in progress (PACK, DRAIN, DONE)
//   done_o         one-cycle pulse after the final write is accepted
// ----------------------------------------------------------------------------
package vpu_alu_wb_packer_pkg;
    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2,
        SEW64 = 2'd3
    } VSEW_e;
endpackage

module vpu_alu_wb_packer
    import vpu_alu_wb_packer_pkg::*;
#(
    parameter  int unsigned VLEN = 128,
    localparam int unsigned WPR  = VLEN / 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [$clog2(VLEN):0]       vl_i,
    input  VSEW_e                       vsew_i,
    input  logic [4:0]                  vd_i,
    input  logic                        mask_dest_i,
    input  logic                        elem_valid_i,
    input  logic                        elem_en_i,
    input  logic [63:0]                 elem_data_i,
    output logic                        elem_ready_o,
    output logic                        vrf_we_o,
    input  logic                        vrf_ready_i,
    output logic [$clog2(32*WPR)-1:0]   vrf_waddr_o,
    output logic [63:0]                 vrf_wdata_o,
    output logic [63:0]                 vrf_wmask_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int unsigned VLW    = $clog2(VLEN) + 1;
    localparam int unsigned AW     = $clog2(32 * WPR);
    localparam int unsigned NWORDS = 32 * WPR;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [VLW-1:0]     vl_q, vl_d;
    VSEW_e              vsew_q, vsew_d;
    logic               mdest_q, mdest_d;
    logic [VLW-1:0]     e_q, e_d;
    logic [AW-1:0]      waddr_q, waddr_d;
    logic [63:0]        pack_data_q, pack_data_d;
    logic [63:0]        pack_mask_q, pack_mask_d;
    logic               buf_valid_q, buf_valid_d;
    logic [63:0]        buf_data_q, buf_data_d;
    logic [63:0]        buf_mask_q, buf_mask_d;
    logic [AW-1:0]      buf_addr_q, buf_addr_d;

    // Element placement, derived from the element counter only
    logic [2:0]         lane;
    logic [3:0]         b_bytes;
    logic [3:0]         end_byte;
    logic [5:0]         bit_idx;
    logic [63:0]        sew_ones;
    logic [63:0]        slice_d;
    logic [63:0]        slice_m;
    logic [63:0]        tail;
    logic               is_last;
    logic               complete;
    logic [63:0]        word_data;
    logic [63:0]        word_mask;
    logic               elem_ready;

    always_comb begin
        // Only the low counter bits matter for the byte lane inside a word.
        lane     = e_q[2:0] << vsew_q;
        b_bytes  = 4'd1 << vsew_q;
        end_byte = {1'b0, lane} + b_bytes;
        bit_idx  = e_q[5:0];
        is_last  = (e_q == (vl_q - VLW'(1)));

        case (vsew_q)
            SEW8:    sew_ones = 64'h0000_0000_0000_00FF;
            SEW16:   sew_ones = 64'h0000_0000_0000_FFFF;
            SEW32:   sew_ones = 64'h0000_0000_FFFF_FFFF;
            default: sew_ones = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase

        if (mdest_q) begin
            slice_d  = {63'd0, elem_data_i[0]} << bit_idx;
            slice_m  = {63'd0, elem_en_i} << bit_idx;
            complete = (bit_idx == 6'd63) || is_last;
        end else begin
            slice_d  = (elem_data_i & sew_ones) << {lane, 3'b000};
            slice_m  = elem_en_i ? (sew_ones << {lane, 3'b000}) : 64'd0;
            complete = end_byte[3] || is_last;
        end

        tail = 64'd0;
`ifdef VPU_WB_TAIL_FILL_EN
        if (is_last) begin
            if (mdest_q) begin
                if (bit_idx != 6'd63) tail = {64{1'b1}} << (bit_idx + 6'd1);
            end else if (!end_byte[3]) begin
                tail = {64{1'b1}} << {end_byte[2:0], 3'b000};
            end
        end
`endif

        word_data = pack_data_q | slice_d | tail;
        word_mask = pack_mask_q | slice_m | tail;
    end

    always_comb begin
        state_d     = state_q;
        vl_d        = vl_q;
        vsew_d      = vsew_q;
        mdest_d     = mdest_q;
        e_d         = e_q;
        waddr_d     = waddr_q;
        pack_data_d = pack_data_q;
        pack_mask_d = pack_mask_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        buf_mask_d  = buf_mask_q;
        buf_addr_d  = buf_addr_q;
        elem_ready  = 1'b0;

        if (buf_valid_q && vrf_ready_i) buf_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    vl_d        = vl_i;
                    vsew_d      = vsew_i;
                    mdest_d     = mask_dest_i;
                    e_d         = '0;
                    // Running word address replaces vd*WPR + word_idx; words
                    // complete strictly in order so an increment suffices.
                    waddr_d     = AW'(32'(vd_i) * WPR);
                    pack_data_d = '0;
                    pack_mask_d = '0;
                    state_d     = (vl_i == '0) ? S_DONE : S_PACK;
                end
            end
            S_PACK: begin
                elem_ready = !(complete && buf_valid_q && !vrf_ready_i);
                if (elem_valid_i && elem_ready) begin
                    e_d = e_q + VLW'(1);
                    if (complete) begin
                        buf_valid_d = 1'b1;
                        buf_data_d  = word_data;
                        buf_mask_d  = word_mask;
                        buf_addr_d  = waddr_q;
                        waddr_d     = (waddr_q == AW'(NWORDS - 1)) ? '0 : waddr_q + AW'(1);
                        pack_data_d = '0;
                        pack_mask_d = '0;
                    end else begin
                        pack_data_d = word_data;
                        pack_mask_d = word_mask;
                    end
                    if (is_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!buf_valid_q || vrf_ready_i) state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vl_q        <= '0;
            vsew_q      <= SEW8;
            mdest_q     <= 1'b0;
            e_q         <= '0;
            waddr_q     <= '0;
            pack_data_q <= '0;
            pack_mask_q <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            buf_mask_q  <= '0;
            buf_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            vl_q        <= vl_d;
            vsew_q      <= vsew_d;
            mdest_q     <= mdest_d;
            e_q         <= e_d;
            waddr_q     <= waddr_d;
            pack_data_q <= pack_data_d;
            pack_mask_q <= pack_mask_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            buf_mask_q  <= buf_mask_d;
            buf_addr_q  <= buf_addr_d;
        end
    end

    assign elem_ready_o = elem_ready;
    assign vrf_we_o     = buf_valid_q;
    assign vrf_waddr_o  = buf_addr_q;
    assign vrf_wdata_o  = buf_data_q;
    assign vrf_wmask_o  = buf_mask_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_vpu_alu_wb_packer.sv
module tb_vpu_alu_wb_packer;
    import vpu_alu_wb_packer_pkg::*;

    localparam int VLEN = 128;
    localparam int VLW  = $clog2(VLEN) + 1;
    localparam int AW   = $clog2(32 * (VLEN / 64));

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [VLW-1:0]  vl_i;
    VSEW_e           vsew_i;
    logic [4:0]      vd_i;
    logic            mask_dest_i;
    logic            elem_valid_i;
    logic            elem_en_i;
    logic [63:0]     elem_data_i;
    logic            elem_ready_o;
    logic            vrf_we_o;
    logic            vrf_ready_i;
    logic [AW-1:0]   vrf_waddr_o;
    logic [63:0]     vrf_wdata_o;
    logic [63:0]     vrf_wmask_o;
    logic            busy_o;
    logic            done_o;

    vpu_alu_wb_packer #(.VLEN(VLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .vl_i         (vl_i),
        .vsew_i       (vsew_i),
        .vd_i         (vd_i),
        .mask_dest_i  (mask_dest_i),
        .elem_valid_i (elem_valid_i),
        .elem_en_i    (elem_en_i),
        .elem_data_i  (elem_data_i),
        .elem_ready_o (elem_ready_o),
        .vrf_we_o     (vrf_we_o),
        .vrf_ready_i  (vrf_ready_i),
        .vrf_waddr_o  (vrf_waddr_o),
        .vrf_wdata_o  (vrf_wdata_o),
        .vrf_wmask_o  (vrf_wmask_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   data;
        logic [63:0]   mask;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_x;
    int  total = 0;
    int  bad = 0;
    int  nwrites = 0;
    int  stalls = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, expv);
        end
    endtask

    task automatic expect_wr(input int addr, input logic [63:0] d, input logic [63:0] m);
        wr_t w;
        w.addr = AW'(addr);
        w.data = d;
        w.mask = m;
        exp_q.push_back(w);
    endtask

    // Scoreboard monitor: a write transfers on the next edge when both
    // request and ready are seen high at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && vrf_we_o && vrf_ready_i) begin
                nwrites++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: addr=%0d data=0x%016h mask=0x%016h", vrf_waddr_o, vrf_wdata_o, vrf_wmask_o);
                end else begin
                    mon_x = exp_q.pop_front();
                    if (vrf_waddr_o !== mon_x.addr || vrf_wdata_o !== mon_x.data || vrf_wmask_o !== mon_x.mask) begin
                        bad++;
                        $display("FAIL write_word: got addr=%0d data=0x%016h mask=0x%016h expected addr=%0d data=0x%016h mask=0x%016h",
                                 vrf_waddr_o, vrf_wdata_o, vrf_wmask_o, mon_x.addr, mon_x.data, mon_x.mask);
                    end
                end
            end
        end
    end

    task automatic start_instr(input int vl, input VSEW_e s, input logic [4:0] vd, input logic md);
        start_i     = 1'b1;
        vl_i        = VLW'(vl);
        vsew_i      = s;
        vd_i        = vd;
        mask_dest_i = md;
        @(posedge clk); #1;
        start_i     = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input logic en);
        elem_valid_i = 1'b1;
        elem_data_i  = d;
        elem_en_i    = en;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (elem_ready_o) break;
            stalls++;
            if (c == 59) begin
                total++; bad++;
                $display("FAIL elem_ready_timeout: got 0 expected 1");
            end
        end
        @(posedge clk); #1;
        elem_valid_i = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done_o) begin cycles = c; break; end
        end
        if (cycles == 0) begin
            total++; bad++;
            $display("FAIL done_timeout: got 0 expected 1");
        end
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done_o}, 64'd0);
        chk("busy_after_done", {63'd0, busy_o}, 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    int cyc;
    int w0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; vl_i = '0; vsew_i = SEW8; vd_i = '0;
        mask_dest_i = 1'b0; elem_valid_i = 1'b0; elem_en_i = 1'b0;
        elem_data_i = '0; vrf_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, and elem_valid_i ignored in IDLE
        elem_valid_i = 1'b1;
        @(negedge clk);
        chk("reset_we",    {63'd0, vrf_we_o}, 64'd0);
        chk("reset_busy",  {63'd0, busy_o}, 64'd0);
        chk("reset_done",  {63'd0, done_o}, 64'd0);
        chk("idle_ready",  {63'd0, elem_ready_o}, 64'd0);
        chk("reset_wdata", vrf_wdata_o, 64'd0);
        chk("reset_wmask", vrf_wmask_o, 64'd0);
        @(posedge clk); #1;
        elem_valid_i = 1'b0;

        // e8, vd=3, vl=8 -> single full word at address 6
        expect_wr(6, 64'h1716151413121110, 64'hFFFF_FFFF_FFFF_FFFF);
        start_instr(8, SEW8, 5'd3, 1'b0);
        for (int e = 0; e < 8; e++) send(64'(e + 'h10), 1'b1);
        @(negedge clk);
        chk("latency_we", {63'd0, vrf_we_o}, 64'd1);
        wait_done(cyc);
        chk("e8_done_latency", 64'(cyc), 64'd1);

        // e32, vl=3, all enabled; upper garbage in element 0 must be masked
        expect_wr(10, 64'hAAAAAAAA_BBBBBBBB, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef VPU_WB_TAIL_FILL_EN
        expect_wr(11, 64'hFFFFFFFF_CCCCCCCC, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        expect_wr(11, 64'h00000000_CCCCCCCC, 64'h0000_0000_FFFF_FFFF);
`endif
        start_instr(3, SEW32, 5'd5, 1'b0);
        send(64'hDEAD0000_BBBBBBBB, 1'b1);
        send(64'h12345678_AAAAAAAA, 1'b1);
        send(64'h00000000_CCCCCCCC, 1'b1);
        wait_done(cyc);

        // e32, vl=3, en = 1,0,1: disabled element keeps its mask bits clear
        expect_wr(10, 64'hAAAAAAAA_BBBBBBBB, 64'h0000_0000_FFFF_FFFF);
`ifdef VPU_WB_TAIL_FILL_EN
        expect_wr(11, 64'hFFFFFFFF_CCCCCCCC, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        expect_wr(11, 64'h00000000_CCCCCCCC, 64'h0000_0000_FFFF_FFFF);
`endif
        start_instr(3, SEW32, 5'd5, 1'b0);
        send(64'h00000000_BBBBBBBB, 1'b1);
        send(64'h00000000_AAAAAAAA, 1'b0);
        send(64'h00000000_CCCCCCCC, 1'b1);
        wait_done(cyc);

        // Mask destination, vl=70, bit0 = e[0], vd=1 -> addresses 2,3
        expect_wr(2, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef VPU_WB_TAIL_FILL_EN
        expect_wr(3, 64'hFFFF_FFFF_FFFF_FFEA, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        expect_wr(3, 64'h0000_0000_0000_002A, 64'h0000_0000_0000_003F);
`endif
        start_instr(70, SEW8, 5'd1, 1'b1);
        for (int e = 0; e < 70; e++) send(64'hFFFF_0000_0000_0000 | 64'(e & 1), 1'b1);
        wait_done(cyc);

        // e16, vl=5, vd=0, with a start pulse mid-instruction that must be ignored
        expect_wr(0, 64'hAAA3_AAA2_AAA1_AAA0, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef VPU_WB_TAIL_FILL_EN
        expect_wr(1, 64'hFFFF_FFFF_FFFF_AAA4, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        expect_wr(1, 64'h0000_0000_0000_AAA4, 64'h0000_0000_0000_FFFF);
`endif
        start_instr(5, SEW16, 5'd0, 1'b0);
        send(64'h5555_0000_0000_AAA0, 1'b1);
        send(64'h0000_0000_0000_AAA1, 1'b1);
        start_instr(0, SEW64, 5'd9, 1'b1);
        chk("busy_ignore_start", {63'd0, busy_o}, 64'd1);
        send(64'h0000_0000_0000_AAA2, 1'b1);
        send(64'h0000_0000_0000_AAA3, 1'b1);
        send(64'h0000_0000_0000_AAA4, 1'b1);
        wait_done(cyc);

        // Backpressure: e64, vl=4, vd=31 (wraps to 0,1); VRF stalls 3 cycles
        for (int e = 0; e < 4; e++) expect_wr((62 + e) % 64, 64'h1000 + 64'(e), 64'hFFFF_FFFF_FFFF_FFFF);
        vrf_ready_i = 1'b0;
        stalls = 0;
        start_instr(4, SEW64, 5'd31, 1'b0);
        fork
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    if (vrf_we_o) break;
                end
                repeat (3) @(posedge clk);
                #1 vrf_ready_i = 1'b1;
            end
        join_none
        for (int e = 0; e < 4; e++) send(64'h1000 + 64'(e), 1'b1);
        chk("bp_stall_cycles", 64'(stalls), 64'd3);
        wait_done(cyc);

        // vl=0: no writes, busy for exactly one cycle with done pulse
        w0 = nwrites;
        start_instr(0, SEW8, 5'd4, 1'b0);
        @(negedge clk);
        // start was sampled one edge earlier; this is the DONE cycle
        chk("vl0_busy",  {63'd0, busy_o}, 64'd1);
        chk("vl0_done",  {63'd0, done_o}, 64'd1);
        chk("vl0_no_we", {63'd0, vrf_we_o}, 64'd0);
        @(negedge clk);
        chk("vl0_busy_end", {63'd0, busy_o}, 64'd0);
        chk("vl0_done_end", {63'd0, done_o}, 64'd0);
        chk("vl0_no_writes", 64'(nwrites - w0), 64'd0);
        @(posedge clk); #1;

        // Async reset in PACK with a pending write
        vrf_ready_i = 1'b0;
        start_instr(4, SEW64, 5'd7, 1'b0);
        send(64'h0BAD_0BAD_0BAD_0BAD, 1'b1);
        @(negedge clk);
        chk("pre_reset_we", {63'd0, vrf_we_o}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_we",    {63'd0, vrf_we_o}, 64'd0);
        chk("rst_busy",  {63'd0, busy_o}, 64'd0);
        chk("rst_ready", {63'd0, elem_ready_o}, 64'd0);
        chk("rst_done",  {63'd0, done_o}, 64'd0);
        chk("rst_wdata", vrf_wdata_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        vrf_ready_i = 1'b1;

        // Normal operation after reset: e64, vl=2, vd=2 -> addresses 4,5
        expect_wr(4, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_wr(5, 64'hFEDC_BA98_7654_3210, 64'd0);
        start_instr(2, SEW64, 5'd2, 1'b0);
        send(64'h0123_4567_89AB_CDEF, 1'b1);
        send(64'hFEDC_BA98_7654_3210, 1'b0);
        wait_done(cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
